idu_decode_stage: RTL and testbench
===================================

// Module: idu_decode_stage
// PURPOSE
//  Decode stage directly downstream of instruction fetch. Accepts {inst, pc} over a valid/ready
//  handshake, decodes RV32I fields, immediates and op class, and holds the result in a one-entry
//  output register toward EXU with its own valid/ready handshake. Supports flush and counts stall cycles.
// PARAMETERS
//  WIDTH     32  PC/data width; inst is always 32 bits
//  CNT_W     32  width of stall_cnt (saturating)
// PORTS
//  clk          in   1        clock, all state updates on posedge
//  rst          in   1        synchronous reset, active-high
//  ifu_valid    in   1        upstream has instruction on ifu_data
//  ifu_data     in   64       [63:32]=inst, [31:0]=pc; stable while ifu_valid high
//  idu_ready    out  1        this stage can accept
//  flush        in   1        discard held and incoming instruction (redirect)
//  idu_valid    out  1        decoded instruction valid toward EXU
//  exu_ready    in   1        EXU accepts decoded instruction
//  idu_pc       out  WIDTH    pc of held instruction
//  idu_inst     out  32       raw instruction
//  idu_rs1/idu_rs2/idu_rd  out 5 each  inst[19:15]/[24:20]/[11:7]
//  idu_imm      out  32       sign-extended immediate per format (0 for R-type/illegal)
//  idu_op       out  4        op class, encoding below
//  idu_rd_wen   out  1        writes rd; forced 0 when rd==0
//  idu_illegal  out  1        unknown opcode
//  stall_cnt    out  CNT_W    cycles with idu_valid && !exu_ready
// BEHAVIOUR
//  Reset: state S_EMPTY; idu_valid=0; all data outputs 0; stall_cnt=0.
//  States: S_EMPTY (no held inst), S_FULL (held inst presented). idu_valid = (state==S_FULL).
//  idu_ready = (state==S_EMPTY) | exu_ready (combinational; pass-through when drained same cycle).
//  accept = ifu_valid & idu_ready & !flush; fire = idu_valid & exu_ready.
//  Transitions: EMPTY->FULL on accept; FULL->FULL on fire&accept (back-to-back, new data loaded);
//   FULL->EMPTY on fire&!accept; FULL holds otherwise with all outputs stable.
//  Latency: accept at edge N -> idu_valid and decoded fields at N+1. Decode is combinational
//   on ifu_data and registered on accept; unaccepted cycles do not change outputs.
//  flush: priority over everything; next state S_EMPTY, incoming inst dropped, data regs unchanged.
//  idu_op: 0 LUI(0110111) 1 AUIPC(0010111) 2 JAL(1101111) 3 JALR(1100111) 4 BRANCH(1100011)
//   5 LOAD(0000011) 6 STORE(0100011) 7 OPIMM(0010011) 8 OP(0110011) 9 SYSTEM(1110011)
//   10 FENCE(0001111) 15 ILLEGAL (any other opcode; illegal=1, imm=0, rd_wen=0).
//  Immediates: I {20{i[31]},i[31:20]}; S {20{i[31]},i[31:25],i[11:7]};
//   B {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}.
//  rd_wen=1 for op 0,1,2,3,5,7,8,9 and rd!=0; 0 otherwise.
//  stall_cnt: +1 each cycle idu_valid & !exu_ready & !flush; saturates at all-ones; cleared only by rst.
//  Reset mid-operation: held instruction discarded, idu_valid low next cycle regardless of handshakes.
// TESTING
//  1 ifu_data={0x00500093,0x80000000}, exu_ready=1 -> next cycle valid=1, op=7, rd=1, rs1=0, imm=5, rd_wen=1.
//  2 inst 0xFE208EE3 (beq x1,x2,-4) -> op=4, rs1=1, rs2=2, imm=0xFFFFFFFC, rd_wen=0.
//  3 inst 0x0020A423 (sw x2,8(x1)) then 0x123452B7 (lui x5) back-to-back, exu_ready=1 -> two consecutive
//     valid cycles; second op=0, rd=5, imm=0x12345000; idu_ready high throughout.
//  4 Load inst with exu_ready=0 for 3 cycles -> outputs stable, idu_ready=0, stall_cnt=3, upstream inst held.
//  5 flush while FULL and ifu_valid=1 -> next cycle idu_valid=0, incoming inst not presented later.
//  6 inst 0x00000000 -> idu_illegal=1, op=15, imm=0; rst asserted while FULL -> idu_valid=0 next cycle.

Source files
------------

// File: rtl/idu_decode_stage.sv
// RV32I decode stage: registers decoded {inst, pc} from IFU into a one-entry
// output buffer toward EXU, with flush and a saturating stall counter.
module idu_decode_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_valid,
    input  logic [63:0]       ifu_data,
    output logic              idu_ready,
    input  logic              flush,
    output logic              idu_valid,
    input  logic              exu_ready,
    output logic [WIDTH-1:0]  idu_pc,
    output logic [31:0]       idu_inst,
    output logic [4:0]        idu_rs1,
    output logic [4:0]        idu_rs2,
    output logic [4:0]        idu_rd,
    output logic [31:0]       idu_imm,
    output logic [3:0]        idu_op,
    output logic              idu_rd_wen,
    output logic              idu_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned OP_W   = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t state_q, state_d;

    logic              accept;
    logic              fire;
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [INST_W-1:0] dec_imm;
    logic [OP_W-1:0]   dec_op;
    logic              dec_illegal;
    logic              dec_rd_wen;

    assign idu_valid = (state_q == S_FULL);
    assign idu_ready = (state_q == S_EMPTY) | exu_ready;
    assign accept    = ifu_valid & idu_ready & ~flush;
    assign fire      = idu_valid & exu_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Next state: flush wins; a drained slot refills in the same cycle
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) state_d = S_FULL;
                S_FULL:  if (fire && !accept) state_d = S_EMPTY;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    assign inst  = ifu_data[63:32];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Opcode decode of the incoming instruction
    always_comb begin
        dec_op      = 4'd15;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        dec_rd_wen  = 1'b0;
        case (inst[6:0])
            OPC_LUI:    begin dec_op = 4'd0;  dec_imm = imm_u; end
            OPC_AUIPC:  begin dec_op = 4'd1;  dec_imm = imm_u; end
            OPC_JAL:    begin dec_op = 4'd2;  dec_imm = imm_j; end
            OPC_JALR:   begin dec_op = 4'd3;  dec_imm = imm_i; end
            OPC_BRANCH: begin dec_op = 4'd4;  dec_imm = imm_b; end
            OPC_LOAD:   begin dec_op = 4'd5;  dec_imm = imm_i; end
            OPC_STORE:  begin dec_op = 4'd6;  dec_imm = imm_s; end
            OPC_OPIMM:  begin dec_op = 4'd7;  dec_imm = imm_i; end
            OPC_OP:     begin dec_op = 4'd8;  end
            OPC_SYSTEM: begin dec_op = 4'd9;  dec_imm = imm_i; end
            OPC_FENCE:  begin dec_op = 4'd10; dec_imm = imm_i; end
            default:    begin dec_illegal = 1'b1; end
        endcase
        case (dec_op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9:
                dec_rd_wen = (inst[11:7] != 5'd0);
            default: dec_rd_wen = 1'b0;
        endcase
    end

    // Output register: loads only on accept, so stalls and flushes leave it intact
    always_ff @(posedge clk) begin
        if (rst) begin
            idu_pc      <= '0;
            idu_inst    <= '0;
            idu_rs1     <= '0;
            idu_rs2     <= '0;
            idu_rd      <= '0;
            idu_imm     <= '0;
            idu_op      <= '0;
            idu_rd_wen  <= 1'b0;
            idu_illegal <= 1'b0;
        end else if (accept) begin
            idu_pc      <= WIDTH'(ifu_data[31:0]);
            idu_inst    <= inst;
            idu_rs1     <= inst[19:15];
            idu_rs2     <= inst[24:20];
            idu_rd      <= inst[11:7];
            idu_imm     <= dec_imm;
            idu_op      <= dec_op;
            idu_rd_wen  <= dec_rd_wen;
            idu_illegal <= dec_illegal;
        end
    end

    // Saturating count of back-pressured cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (idu_valid && !exu_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_idu_decode_stage.sv
// Randomized and directed bench for idu_decode_stage against a transaction-level
// reference model of the decode stage.
module tb_idu_decode_stage;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  op;
        logic        rd_wen;
        logic        illegal;
    } dec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifu_valid;
    logic [63:0]       ifu_data;
    logic              idu_ready;
    logic              flush;
    logic              idu_valid;
    logic              exu_ready;
    logic [WIDTH-1:0]  idu_pc;
    logic [31:0]       idu_inst;
    logic [4:0]        idu_rs1, idu_rs2, idu_rd;
    logic [31:0]       idu_imm;
    logic [3:0]        idu_op;
    logic              idu_rd_wen;
    logic              idu_illegal;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit                m_full  = 1'b0;
    dec_t              m_dec   = '0;
    logic [CNT_W-1:0]  m_stall = '0;

    idu_decode_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_data(ifu_data),
        .idu_ready(idu_ready), .flush(flush), .idu_valid(idu_valid),
        .exu_ready(exu_ready), .idu_pc(idu_pc), .idu_inst(idu_inst),
        .idu_rs1(idu_rs1), .idu_rs2(idu_rs2), .idu_rd(idu_rd),
        .idu_imm(idu_imm), .idu_op(idu_op), .idu_rd_wen(idu_rd_wen),
        .idu_illegal(idu_illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic dec_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        dec_t        d;
        logic [12:0] b;
        logic [20:0] j;
        int          fmt;   // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
        d = '0;
        d.pc = pc; d.inst = i;
        d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
        fmt = 0;
        case (i[6:0])
            7'b0110111: begin d.op = 4'd0;  fmt = 4; end
            7'b0010111: begin d.op = 4'd1;  fmt = 4; end
            7'b1101111: begin d.op = 4'd2;  fmt = 5; end
            7'b1100111: begin d.op = 4'd3;  fmt = 1; end
            7'b1100011: begin d.op = 4'd4;  fmt = 3; end
            7'b0000011: begin d.op = 4'd5;  fmt = 1; end
            7'b0100011: begin d.op = 4'd6;  fmt = 2; end
            7'b0010011: begin d.op = 4'd7;  fmt = 1; end
            7'b0110011: begin d.op = 4'd8;  fmt = 0; end
            7'b1110011: begin d.op = 4'd9;  fmt = 1; end
            7'b0001111: begin d.op = 4'd10; fmt = 1; end
            default:    begin d.op = 4'd15; fmt = 0; end
        endcase
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (fmt)
            1: d.imm = 32'($signed(i) >>> 20);
            2: d.imm = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
            3: d.imm = 32'($signed(b));
            4: d.imm = i & 32'hFFFF_F000;
            5: d.imm = 32'($signed(j));
            default: d.imm = 32'd0;
        endcase
        d.illegal = (d.op == 4'd15);
        d.rd_wen  = (d.op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8, 4'd9}) && (d.rd != 5'd0);
        return d;
    endfunction

    function automatic dec_t obs();
        dec_t d;
        d.pc = idu_pc; d.inst = idu_inst; d.rs1 = idu_rs1; d.rs2 = idu_rs2; d.rd = idu_rd;
        d.imm = idu_imm; d.op = idu_op; d.rd_wen = idu_rd_wen; d.illegal = idu_illegal;
        return d;
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic er,
                         input logic fl, input logic r);
        ifu_valid = v; ifu_data = d; exu_ready = er; flush = fl; rst = r;
        #1;
    endtask

    // Update the model from the currently driven inputs, then cross one clock edge
    task automatic advance();
        bit rdy, acc, fire;
        rdy  = !m_full || exu_ready;
        acc  = ifu_valid && rdy && !flush;
        fire = m_full && exu_ready;
        if (rst) begin
            m_full = 1'b0; m_dec = '0; m_stall = '0;
        end else begin
            if (m_full && !exu_ready && !flush && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if (flush)      m_full = 1'b0;
            else if (acc)   begin m_full = 1'b1; m_dec = ref_decode(ifu_data[63:32], ifu_data[31:0]); end
            else if (fire)  m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        advance(); advance();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        n_tests++; if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", idu_valid); end
        n_tests++; if (obs() !== dec_t'(0)) begin n_fail++; $display("FAIL reset_data: got %h want 0", obs()); end
        n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        n_tests++; if (idu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", idu_ready); end
    endtask

    task automatic test_addi();
        drive(1'b1, {32'h0050_0093, 32'h8000_0000}, 1'b1, 1'b0, 1'b0);
        advance();
        n_tests++; if (idu_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", idu_valid); end
        n_tests++; if ({idu_op, idu_rd, idu_rs1} !== {4'd7, 5'd1, 5'd0}) begin n_fail++;
            $display("FAIL addi_fields: got op=%0d rd=%0d rs1=%0d want 7/1/0", idu_op, idu_rd, idu_rs1); end
        n_tests++; if ({idu_imm, idu_rd_wen} !== {32'd5, 1'b1}) begin n_fail++;
            $display("FAIL addi_imm: got imm=%h wen=%b want 5/1", idu_imm, idu_rd_wen); end
        n_tests++; if (idu_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL addi_pc: got %h want 80000000", idu_pc); end
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        advance();
        n_tests++; if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", idu_valid); end
    endtask

    task automatic test_branch();
        drive(1'b1, {32'hFE20_8EE3, 32'h0000_1000}, 1'b1, 1'b0, 1'b0);
        advance();
        n_tests++; if ({idu_valid, idu_op, idu_rs1, idu_rs2} !== {1'b1, 4'd4, 5'd1, 5'd2}) begin n_fail++;
            $display("FAIL beq_fields: got v=%b op=%0d rs1=%0d rs2=%0d want 1/4/1/2", idu_valid, idu_op, idu_rs1, idu_rs2); end
        n_tests++; if ({idu_imm, idu_rd_wen} !== {32'hFFFF_FFFC, 1'b0}) begin n_fail++;
            $display("FAIL beq_imm: got imm=%h wen=%b want fffffffc/0", idu_imm, idu_rd_wen); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, {32'h0020_A423, 32'h0000_2000}, 1'b1, 1'b0, 1'b0);
        n_tests++; if (idu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", idu_ready); end
        advance();
        n_tests++; if ({idu_valid, idu_op, idu_imm} !== {1'b1, 4'd6, 32'd8}) begin n_fail++;
            $display("FAIL b2b_sw: got v=%b op=%0d imm=%h want 1/6/8", idu_valid, idu_op, idu_imm); end
        drive(1'b1, {32'h1234_52B7, 32'h0000_2004}, 1'b1, 1'b0, 1'b0);
        n_tests++; if (idu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", idu_ready); end
        advance();
        n_tests++; if ({idu_valid, idu_op, idu_rd, idu_imm, idu_rd_wen} !== {1'b1, 4'd0, 5'd5, 32'h1234_5000, 1'b1}) begin n_fail++;
            $display("FAIL b2b_lui: got v=%b op=%0d rd=%0d imm=%h wen=%b want 1/0/5/12345000/1",
                     idu_valid, idu_op, idu_rd, idu_imm, idu_rd_wen); end
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        n_tests++; if (idu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", idu_ready); end
        advance();
        n_tests++; if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", idu_valid); end
    endtask

    task automatic test_stall();
        dec_t snap;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        advance();
        drive(1'b1, {32'h0000_A183, 32'h0000_3000}, 1'b0, 1'b0, 1'b0);
        advance();
        snap = obs();
        n_tests++; if ({idu_valid, idu_op, idu_rd} !== {1'b1, 4'd5, 5'd3}) begin n_fail++;
            $display("FAIL stall_load: got v=%b op=%0d rd=%0d want 1/5/3", idu_valid, idu_op, idu_rd); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, {32'h0010_0113, 32'h0000_3004}, 1'b0, 1'b0, 1'b0);
            n_tests++; if (idu_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 0", k, idu_ready); end
            advance();
            n_tests++; if ({idu_valid, obs()} !== {1'b1, snap}) begin n_fail++;
                $display("FAIL stall_hold%0d: got v=%b %h want 1 %h", k, idu_valid, obs(), snap); end
        end
        n_tests++; if (stall_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL stall_cnt3: got %0d want 3", stall_cnt); end
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, {32'h0010_0113, 32'h0000_3004}, 1'b0, 1'b0, 1'b0);
            advance();
        end
        n_tests++; if (stall_cnt !== CNT_W'(15)) begin n_fail++; $display("FAIL stall_sat: got %0d want 15", stall_cnt); end
        drive(1'b1, {32'h0010_0113, 32'h0000_3004}, 1'b1, 1'b0, 1'b0);
        n_tests++; if (idu_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b want 1", idu_ready); end
        advance();
        n_tests++; if ({idu_valid, idu_inst, idu_pc} !== {1'b1, 32'h0010_0113, 32'h0000_3004}) begin n_fail++;
            $display("FAIL stall_next: got v=%b inst=%h pc=%h want 1/00100113/00003004", idu_valid, idu_inst, idu_pc); end
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_flush();
        dec_t snap;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        advance();
        drive(1'b1, {32'h0050_0093, 32'h0000_4000}, 1'b0, 1'b0, 1'b0);
        advance();
        snap = obs();
        drive(1'b1, {32'h0070_0113, 32'h0000_4004}, 1'b0, 1'b1, 1'b0);
        advance();
        n_tests++; if (idu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", idu_valid); end
        n_tests++; if (obs() !== snap) begin n_fail++; $display("FAIL flush_data: got %h want %h", obs(), snap); end
        n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL flush_stall: got %0d want 0", stall_cnt); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
            advance();
            n_tests++; if ({idu_valid, idu_inst} !== {1'b0, 32'h0050_0093}) begin n_fail++;
                $display("FAIL flush_after%0d: got v=%b inst=%h want 0/00500093", k, idu_valid, idu_inst); end
        end
    endtask

    task automatic test_illegal_reset();
        drive(1'b1, {32'h0000_0000, 32'h0000_5000}, 1'b0, 1'b0, 1'b0);
        advance();
        n_tests++; if ({idu_valid, idu_illegal, idu_op, idu_imm, idu_rd_wen} !== {1'b1, 1'b1, 4'd15, 32'd0, 1'b0}) begin n_fail++;
            $display("FAIL illegal: got v=%b ill=%b op=%0d imm=%h wen=%b want 1/1/15/0/0",
                     idu_valid, idu_illegal, idu_op, idu_imm, idu_rd_wen); end
        drive(1'b1, {32'h0050_0093, 32'h0000_5004}, 1'b1, 1'b0, 1'b1);
        advance();
        n_tests++; if ({idu_valid, idu_pc, idu_op, idu_illegal} !== {1'b0, 32'd0, 4'd0, 1'b0}) begin n_fail++;
            $display("FAIL midrst: got v=%b pc=%h op=%0d ill=%b want 0/0/0/0", idu_valid, idu_pc, idu_op, idu_illegal); end
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0]  opcs [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                                   7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b0001111, 7'b1111111};
        logic [31:0] r, pc;
        logic [63:0] d;
        logic        v, held;
        held = 1'b0; d = '0; v = 1'b0; pc = 32'h0001_0000;
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                r  = $urandom();
                v  = ($urandom_range(0, 3) != 0);
                pc = pc + 32'd4;
                d  = {r[31:7], opcs[$urandom_range(0, 11)], pc};
            end
            drive(v, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), 1'b0);
            n_tests++; if (idu_ready !== (!m_full || exu_ready)) begin n_fail++;
                $display("FAIL rnd_ready c%0d: got %b want %b", c, idu_ready, (!m_full || exu_ready)); end
            held = v && !(!m_full || exu_ready) && !flush;
            advance();
            n_tests++; if ({idu_valid, stall_cnt} !== {m_full, m_stall}) begin n_fail++;
                $display("FAIL rnd_ctrl c%0d: got v=%b stall=%0d want v=%b stall=%0d", c, idu_valid, stall_cnt, m_full, m_stall); end
            n_tests++; if (obs() !== m_dec) begin n_fail++;
                $display("FAIL rnd_data c%0d: got %h want %h", c, obs(), m_dec); end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
